bcd_display_mux: RTL and testbench

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

---
 rtl/bcd_display_mux.sv | 39 +++
 tb/tb_bcd_display_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: captures a two-digit BCD value and time-multiplexes it onto one 7-segment display
module bcd_display_mux #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LD,
  input  logic [7:0] D,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       ERR
);
  localparam logic [15:0][6:0] LUT = {{6{7'h79}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [15:0] cnt;
  logic [7:0]  h;
  logic        sel, wrap, blank;
  assign wrap = cnt == 16'(REFRESH_DIV - 1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt <= '0;
      sel <= 1'b0;
      h   <= '0;
      ERR <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 16'd1;
      sel <= sel ^ wrap;
      if (LD) begin
        h   <= D;
        ERR <= (D[7:4] > 4'd9) || (D[3:0] > 4'd9);
      end
    end
  // Tens digit is blanked when zero; ones digit is always lit.
  always_comb begin
    blank = sel && h[7:4] == 4'd0;
    AN    = blank ? 2'b00 : sel ? 2'b10 : 2'b01;
    SEG   = blank ? 7'h00 : LUT[sel ? h[7:4] : h[3:0]];
  end
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: table, hand-sequence and random checks of bcd_display_mux against a scan-time model
module tb_bcd_display_mux;
  localparam int R = 4;
  localparam int P = 2 * R;
  typedef struct {
    logic [7:0] d;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic [1:0] an_tens;
    logic       err;
  } vec_t;
  logic       CLK = 0, RST_N = 0, LD = 0, clk_en = 0;
  logic [7:0] D = 0;
  logic [6:0] SEG, SEG1;
  logic [1:0] AN, AN1;
  logic       ERR, ERR1;
  int         n_chk = 0, n_fail = 0, n = 0;
  logic [7:0] hm = 0;
  logic       em = 0;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
  logic [6:0] seq_seg [8] = '{7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h3F};
  logic [1:0] seq_an  [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  vec_t       vt [10];

  bcd_display_mux #(.REFRESH_DIV(R)) dut (
    .CLK(CLK), .RST_N(RST_N), .LD(LD), .D(D), .SEG(SEG), .AN(AN), .ERR(ERR));
  bcd_display_mux #(.REFRESH_DIV(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .LD(LD), .D(D), .SEG(SEG1), .AN(AN1), .ERR(ERR1));

  always #5 if (clk_en) CLK = ~CLK;

  // Model: n = edges since reset release, hm/em = last captured value and its error flag.
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      n = 0; hm = 0; em = 0;
    end else begin
      n++;
      if (LD) begin
        hm = D;
        em = (D[7:4] > 9) || (D[3:0] > 9);
      end
    end

  function automatic logic [8:0] model_out(int r);
    logic sel;
    sel = ((n / r) % 2) == 1;
    if (!sel) return {2'b01, lut[hm[3:0]]};
    if (hm[7:4] == 0) return 9'h000;
    return {2'b10, lut[hm[7:4]]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [8:0] m, m1;
    m  = model_out(R);
    m1 = model_out(1);
    chk("seg", 32'(SEG), 32'(m[6:0]));
    chk("an", 32'(AN), 32'(m[8:7]));
    chk("err", 32'(ERR), 32'(em));
    chk("an_not_11", 32'(AN != 2'b11), 32'd1);
    chk("seg_div1", 32'(SEG1), 32'(m1[6:0]));
    chk("an_div1", 32'(AN1), 32'(m1[8:7]));
    chk("err_div1", 32'(ERR1), 32'(em));
  endtask

  task automatic cyc(input logic ld, input logic [7:0] d);
    @(negedge CLK);
    check_model();
    LD = ld;
    D  = d;
  endtask

  task automatic align(input int k);
    for (int i = 0; i < 2 * P && (n % P) != k; i++) cyc(1'b0, 8'h00);
    chk("align", 32'(n % P), 32'(k));
  endtask

  initial begin
    vt[0] = '{8'h30, 7'h3F, 7'h4F, 2'b10, 1'b0};
    vt[1] = '{8'h07, 7'h07, 7'h00, 2'b00, 1'b0};
    vt[2] = '{8'h1C, 7'h79, 7'h06, 2'b10, 1'b1};
    vt[3] = '{8'h18, 7'h7F, 7'h06, 2'b10, 1'b0};
    vt[4] = '{8'h00, 7'h3F, 7'h00, 2'b00, 1'b0};
    vt[5] = '{8'h99, 7'h6F, 7'h6F, 2'b10, 1'b0};
    vt[6] = '{8'hA5, 7'h6D, 7'h79, 2'b10, 1'b1};
    vt[7] = '{8'h42, 7'h5B, 7'h66, 2'b10, 1'b0};
    vt[8] = '{8'h5F, 7'h79, 7'h6D, 2'b10, 1'b1};
    vt[9] = '{8'h81, 7'h06, 7'h7F, 2'b10, 1'b0};
    // Reset with the clock stopped
    #20;
    chk("rst_seg", 32'(SEG), 32'h3F);
    chk("rst_an", 32'(AN), 32'h1);
    chk("rst_err", 32'(ERR), 32'h0);
    clk_en = 1;
    @(negedge CLK);
    RST_N = 1;
    // Normal scan of 30
    LD = 1; D = 8'h30;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00);
      chk("scan_seg", 32'(SEG), 32'(seq_seg[i]));
      chk("scan_an", 32'(AN), 32'(seq_an[i]));
    end
    // Decode table, each loaded on the wrap edge into the ones slot
    foreach (vt[i]) begin
      align(P - 1);
      LD = 1; D = vt[i].d;
      cyc(1'b0, 8'h00);
      chk("tbl_ones_seg", 32'(SEG), 32'(vt[i].seg_ones));
      chk("tbl_ones_an", 32'(AN), 32'h1);
      chk("tbl_err", 32'(ERR), 32'(vt[i].err));
      align(R);
      chk("tbl_tens_seg", 32'(SEG), 32'(vt[i].seg_tens));
      chk("tbl_tens_an", 32'(AN), 32'(vt[i].an_tens));
    end
    // Load mid-slot, then load on the wrap into tens
    align(1);
    LD = 1; D = 8'h25;
    cyc(1'b0, 8'h00);
    chk("mid_seg", 32'(SEG), 32'h6D);
    chk("mid_an", 32'(AN), 32'h1);
    cyc(1'b0, 8'h00);
    chk("mid_an2", 32'(AN), 32'h1);
    cyc(1'b0, 8'h00);
    chk("mid_tens_seg", 32'(SEG), 32'h5B);
    chk("mid_tens_an", 32'(AN), 32'h2);
    align(R - 1);
    LD = 1; D = 8'h09;
    cyc(1'b0, 8'h00);
    chk("wrap_blank_seg", 32'(SEG), 32'h00);
    chk("wrap_blank_an", 32'(AN), 32'h0);
    align(0);
    chk("wrap_ones_seg", 32'(SEG), 32'h6F);
    // Async reset in the tens slot with a pending load
    align(P - 1);
    LD = 1; D = 8'h99;
    cyc(1'b0, 8'h00);
    align(R + 1);
    chk("pre_rst_seg", 32'(SEG), 32'h6F);
    LD = 1; D = 8'h55;
    #2 RST_N = 0;
    #1;
    chk("arst_seg", 32'(SEG), 32'h3F);
    chk("arst_an", 32'(AN), 32'h1);
    chk("arst_err", 32'(ERR), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    LD = 0; D = 8'h00;
    RST_N = 1;
    chk("rel_an0", 32'(AN), 32'h1);
    for (int i = 1; i <= R; i++) begin
      cyc(1'b0, 8'h00);
      chk("rel_an", 32'(AN), i < R ? 32'h1 : 32'h0);
      chk("rel_seg", 32'(SEG), i < R ? 32'h3F : 32'h00);
    end
    // Random loads, including held-high LD runs
    for (int i = 0; i < 400; i++) cyc($urandom_range(0, 9) < 4, 8'($urandom));
    cyc(1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
